// File: rtl/mont_exp_sequencer.sv
// Modular exponentiation sequencer: maps operands into the Montgomery
// domain, hands them to an external ladder, then maps the result back.
`ifndef BITS
`define BITS 8
`endif
`ifndef LOG_BITS
`define LOG_BITS 3
`endif

module montgomery_mult (
    input  logic [`BITS-1:0] a_i,
    input  logic [`BITS-1:0] b_i,
    input  logic [`BITS-1:0] n_i,
    input  logic [`BITS-1:0] n_prime_i,
    output logic [`BITS-1:0] p_o
);
    localparam int W = `BITS;

    logic [2*W-1:0] t;
    logic [W-1:0]   m;
    logic [2*W-1:0] mn;
    logic [2*W:0]   u;
    logic [W:0]     s;

    // REDC: t + m*N is an exact multiple of R, and the quotient is below 2N
    always_comb begin
        t   = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
        m   = t[W-1:0] * n_prime_i;
        mn  = {{W{1'b0}}, m} * {{W{1'b0}}, n_i};
        u   = {1'b0, t} + {1'b0, mn};
        s   = u[2*W:W];
        p_o = (s >= {1'b0, n_i}) ? s[W-1:0] - n_i : s[W-1:0];
    end
endmodule

module mont_exp_sequencer (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [`BITS-1:0] base,
    input  logic [`BITS-1:0] exponent,
    input  logic [`BITS-1:0] N,
    input  logic [`BITS-1:0] N_prime,
    input  logic [`BITS-1:0] R2,
    output logic             busy,
    output logic             done,
    output logic [`BITS-1:0] result,
    output logic             lad_start,
    output logic [`BITS-1:0] lad_base_mont,
    output logic [`BITS-1:0] lad_one_mont,
    output logic [`BITS-1:0] lad_exponent,
    output logic [`BITS-1:0] lad_N,
    output logic [`BITS-1:0] lad_N_prime,
    input  logic             lad_finish,
    input  logic [`BITS-1:0] lad_result
);
    localparam int W = `BITS;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_BASE,
        S_TO_ONE,
        S_LAD_GO,
        S_LAD_WAIT,
        S_FROM_MONT,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] base_q, base_d;
    logic [W-1:0] exp_q, exp_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] np_q, np_d;
    logic [W-1:0] r2_q, r2_d;
    logic [W-1:0] bm_q, bm_d;
    logic [W-1:0] om_q, om_d;
    logic [W-1:0] lr_q, lr_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] mm_a, mm_b, mm_p;

    montgomery_mult u_mm (
        .a_i      (mm_a),
        .b_i      (mm_b),
        .n_i      (n_q),
        .n_prime_i(np_q),
        .p_o      (mm_p)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        exp_d     = exp_q;
        n_d       = n_q;
        np_d      = np_q;
        r2_d      = r2_q;
        bm_d      = bm_q;
        om_d      = om_q;
        lr_d      = lr_q;
        res_d     = res_q;
        mm_a      = base_q;
        mm_b      = r2_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        lad_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    n_d     = N;
                    np_d    = N_prime;
                    r2_d    = R2;
                    state_d = S_TO_BASE;
                end
            end
            S_TO_BASE: begin
                bm_d    = mm_p;
                state_d = S_TO_ONE;
            end
            S_TO_ONE: begin
                mm_a    = ONE;
                om_d    = mm_p;
                state_d = S_LAD_GO;
            end
            S_LAD_GO: begin
                lad_start = 1'b1;
                state_d   = S_LAD_WAIT;
            end
            S_LAD_WAIT: begin
                if (lad_finish) begin
                    lr_d    = lad_result;
                    state_d = S_FROM_MONT;
                end
            end
            S_FROM_MONT: begin
                mm_a    = lr_q;
                mm_b    = ONE;
                res_d   = mm_p;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            np_q    <= '0;
            r2_q    <= '0;
            bm_q    <= '0;
            om_q    <= '0;
            lr_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            n_q     <= n_d;
            np_q    <= np_d;
            r2_q    <= r2_d;
            bm_q    <= bm_d;
            om_q    <= om_d;
            lr_q    <= lr_d;
            res_q   <= res_d;
        end
    end

    assign result        = res_q;
    assign lad_base_mont = bm_q;
    assign lad_one_mont  = om_q;
    assign lad_exponent  = exp_q;
    assign lad_N         = n_q;
    assign lad_N_prime   = np_q;
endmodule

// File: tb/tb_mont_exp_sequencer.sv
// Bench for mont_exp_sequencer with a behavioural Montgomery ladder,
// a stub-ladder mode and a scoreboard of expected results.
`timescale 1ns/1ps
`ifndef BITS
`define BITS 8
`endif

module tb_mont_exp_sequencer;
    localparam int W    = `BITS;
    localparam int NMOD = 13;
    localparam int NPR  = 59;
    localparam int R2V  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0;
    logic [W-1:0] exponent = '0;
    logic [W-1:0] N = W'(NMOD);
    logic [W-1:0] N_prime = W'(NPR);
    logic [W-1:0] R2 = W'(R2V);
    logic         busy, done, lad_start;
    logic [W-1:0] result;
    logic [W-1:0] lad_base_mont, lad_one_mont, lad_exponent;
    logic [W-1:0] lad_N, lad_N_prime;
    logic         lad_finish;
    logic [W-1:0] lad_result;

    logic         lf_model = 1'b0;
    logic         lf_spur = 1'b0;
    logic [W-1:0] lr_model = '0;
    assign lad_finish = lf_model | lf_spur;
    assign lad_result = lf_spur ? {W{1'b1}} : lr_model;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    mont_exp_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base         (base),
        .exponent     (exponent),
        .N            (N),
        .N_prime      (N_prime),
        .R2           (R2),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .lad_start    (lad_start),
        .lad_base_mont(lad_base_mont),
        .lad_one_mont (lad_one_mont),
        .lad_exponent (lad_exponent),
        .lad_N        (lad_N),
        .lad_N_prime  (lad_N_prime),
        .lad_finish   (lad_finish),
        .lad_result   (lad_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int mm(int a, int b);
        int ri = 0;
        for (int x = 0; x < NMOD; x++)
            if (((x << W) % NMOD) == 1) ri = x;
        return (((a * b) % NMOD) * ri) % NMOD;
    endfunction

    function automatic int modexp(int b, int e);
        int r = 1 % NMOD;
        for (int i = 0; i < e; i++) r = (r * b) % NMOD;
        return r;
    endfunction

    function automatic int ladder(int bm, int om, logic [W-1:0] e);
        int r0 = om;
        int r1 = bm;
        for (int i = W - 1; i >= 0; i--) begin
            if (e[i]) begin
                r0 = mm(r0, r1);
                r1 = mm(r1, r1);
            end else begin
                r1 = mm(r0, r1);
                r0 = mm(r0, r0);
            end
        end
        return r0;
    endfunction

    // ladder model: shares rst, answers lad_delay cycles after lad_start
    int           lad_delay = 6;
    bit           stub_mode = 1'b0;
    logic [W-1:0] stub_val = W'(9);
    bit           rst_s = 1'b1;
    always @(posedge clk) rst_s <= rst;

    initial begin : ladder_model
        int cnt;
        bit pend;
        int res;
        cnt = 0;
        pend = 0;
        res = 0;
        forever begin
            @(negedge clk);
            lf_model = 1'b0;
            if (rst_s) pend = 0;
            else if (pend) begin
                if (cnt == 0) begin
                    lf_model = 1'b1;
                    lr_model = W'(res);
                    pend = 0;
                end else cnt--;
            end
            if (lad_start && !rst_s) begin
                pend = 1;
                cnt = lad_delay - 1;
                res = stub_mode ? int'(stub_val)
                    : ladder(int'(lad_base_mont), int'(lad_one_mont), lad_exponent);
            end
        end
    end

    int           lad_cnt = 0;
    int           done_cnt = 0;
    int           lad_cyc = 0;
    int           fin_cyc = 0;
    logic [W-1:0] mon_bm = '0;
    logic [W-1:0] mon_om = '0;
    logic [W-1:0] mon_n = '0;
    logic [W-1:0] mon_np = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lad_start) begin
            lad_cnt <= lad_cnt + 1;
            lad_cyc <= cyc;
            mon_bm  <= lad_base_mont;
            mon_om  <= lad_one_mont;
            mon_n   <= lad_N;
            mon_np  <= lad_N_prime;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (lad_finish) fin_cyc <= cyc;
    end

    task automatic issue(input int b, input int e, input int expv);
        base = W'(b);
        exponent = W'(e);
        N = W'(NMOD);
        N_prime = W'(NPR);
        R2 = W'(R2V);
        start = 1'b1;
        exp_q.push_back(W'(expv));
        @(negedge clk);
        start = 1'b0;
        base = W'($urandom);
        exponent = W'($urandom);
        N = W'($urandom);
        N_prime = W'($urandom);
        R2 = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit seen);
        lat = 0;
        seen = 0;
        while (!seen && lat < 300) begin
            if (done === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        base = W'(2);
        exponent = W'(5);
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rst_done: got %b want 0", done);
        end
        vectors++;
        if (lad_start !== 1'b0) begin
            errors++; $display("FAIL rst_lad_start: got %b want 0", lad_start);
        end
        vectors++;
        if (result !== '0) begin
            errors++; $display("FAIL rst_result: got %0d want 0", result);
        end
        vectors++;
        if (lad_base_mont !== '0) begin
            errors++; $display("FAIL rst_bm: got %0d want 0", lad_base_mont);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL start_with_rst: got busy %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit seen;
        int c1;
        int l0;
        logic [W-1:0] expv;
        lad_delay = 6;
        stub_mode = 0;
        l0 = lad_cnt;
        issue(2, 5, modexp(2, 5));
        c1 = cyc;
        wait_done(lat, seen);
        expv = exp_q.pop_front();
        vectors++;
        if (!seen) begin
            errors++; $display("FAIL basic_done: got none want pulse");
        end
        vectors++;
        if (result !== expv) begin
            errors++; $display("FAIL basic_result: got %0d want %0d", result, expv);
        end
        vectors++;
        if (lat != 10) begin
            errors++; $display("FAIL basic_latency: got %0d want 10", lat);
        end
        vectors++;
        if (mon_bm !== W'(5)) begin
            errors++; $display("FAIL basic_base_mont: got %0d want 5", mon_bm);
        end
        vectors++;
        if (mon_om !== W'(9)) begin
            errors++; $display("FAIL basic_one_mont: got %0d want 9", mon_om);
        end
        vectors++;
        if (mon_n !== W'(NMOD) || mon_np !== W'(NPR)) begin
            errors++; $display("FAIL basic_lad_n: got %0d/%0d want %0d/%0d", mon_n, mon_np, NMOD, NPR);
        end
        vectors++;
        if (lad_cyc - c1 != 2) begin
            errors++; $display("FAIL basic_lad_start_cycle: got %0d want 3", lad_cyc - c1 + 1);
        end
        vectors++;
        if (lad_cnt - l0 != 1) begin
            errors++; $display("FAIL basic_lad_pulses: got %0d want 1", lad_cnt - l0);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after: got done %b busy %b want 0 0", done, busy);
        end
        vectors++;
        if (result !== expv) begin
            errors++; $display("FAIL basic_hold: got %0d want %0d", result, expv);
        end
    endtask

    task automatic test_exponents();
        int bs[6] = '{7, 0, 12, 1, 5, 11};
        int es[6] = '{0, 9, 255, 1, 13, 200};
        int b;
        int e;
        int lat;
        bit seen;
        logic [W-1:0] expv;
        for (int i = 0; i < 10; i++) begin
            b = (i < 6) ? bs[i] : int'($urandom_range(NMOD - 1, 0));
            e = (i < 6) ? es[i] : int'($urandom_range(255, 0));
            issue(b, e, modexp(b, e));
            wait_done(lat, seen);
            expv = exp_q.pop_front();
            vectors++;
            if (!seen || result !== expv) begin
                errors++;
                $display("FAIL exp_%0d_pow_%0d: got %0d want %0d", b, e, result, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stub();
        int lat;
        bit seen;
        bit dropped;
        logic [W-1:0] expv;
        lad_delay = 40;
        stub_mode = 1;
        stub_val = W'(9);
        dropped = 0;
        lat = 0;
        seen = 0;
        issue(3, 4, 1);
        while (!seen && lat < 300) begin
            if (done === 1'b1) seen = 1;
            else begin
                if (busy !== 1'b1) dropped = 1;
                @(negedge clk);
                lat++;
            end
        end
        expv = exp_q.pop_front();
        vectors++;
        if (!seen || result !== expv) begin
            errors++; $display("FAIL stub_result: got %0d want %0d", result, expv);
        end
        vectors++;
        if (cyc - fin_cyc != 2) begin
            errors++; $display("FAIL stub_done_delay: got %0d want 2", cyc - fin_cyc);
        end
        vectors++;
        if (dropped || busy !== 1'b1) begin
            errors++; $display("FAIL stub_busy: got low want high");
        end
        stub_mode = 0;
        lad_delay = 6;
        @(negedge clk);
    endtask

    task automatic test_ignored();
        int lat;
        bit seen;
        int l0;
        int d0;
        logic [W-1:0] expv;
        lad_delay = 6;
        l0 = lad_cnt;
        d0 = done_cnt;
        issue(2, 5, modexp(2, 5));
        start = 1'b1;
        base = W'(7);
        exponent = W'(3);
        @(negedge clk);
        start = 1'b0;
        lf_spur = 1'b1;
        @(negedge clk);
        lf_spur = 1'b0;
        wait_done(lat, seen);
        expv = exp_q.pop_front();
        vectors++;
        if (!seen || result !== expv) begin
            errors++; $display("FAIL ign_result: got %0d want %0d", result, expv);
        end
        vectors++;
        if (lat != 8) begin
            errors++; $display("FAIL ign_latency: got %0d want 8", lat);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0);
        end
        vectors++;
        if (lad_cnt - l0 != 1 || mon_bm !== W'(5)) begin
            errors++; $display("FAIL ign_ladder: got %0d starts bm %0d want 1 bm 5", lad_cnt - l0, mon_bm);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        int d0;
        logic [W-1:0] expv;
        lad_delay = 20;
        d0 = done_cnt;
        issue(2, 5, modexp(2, 5));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state: got busy %b done %b want 0 0", busy, done);
        end
        vectors++;
        if (result !== '0) begin
            errors++; $display("FAIL mid_rst_result: got %0d want 0", result);
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        lad_delay = 6;
        issue(6, 7, modexp(6, 7));
        wait_done(lat, seen);
        expv = exp_q.pop_front();
        vectors++;
        if (!seen || result !== expv) begin
            errors++; $display("FAIL mid_rst_restart: got %0d want %0d", result, expv);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bs[3] = '{3, 9, 4};
        int es[3] = '{4, 11, 200};
        int lat;
        bit seen;
        int prev;
        int l0;
        int d0;
        logic [W-1:0] expv;
        lad_delay = 4;
        l0 = lad_cnt;
        d0 = done_cnt;
        prev = 0;
        N = W'(NMOD);
        N_prime = W'(NPR);
        R2 = W'(R2V);
        base = W'(bs[0]);
        exponent = W'(es[0]);
        start = 1'b1;
        exp_q.push_back(W'(modexp(bs[0], es[0])));
        for (int i = 0; i < 3; i++) begin
            wait_done(lat, seen);
            expv = exp_q.pop_front();
            vectors++;
            if (!seen || result !== expv) begin
                errors++; $display("FAIL b2b_result_%0d: got %0d want %0d", i, result, expv);
            end
            if (i > 0) begin
                vectors++;
                if (cyc - prev != 10) begin
                    errors++; $display("FAIL b2b_spacing_%0d: got %0d want 10", i, cyc - prev);
                end
            end
            prev = cyc;
            if (i < 2) begin
                base = W'(bs[i+1]);
                exponent = W'(es[i+1]);
                exp_q.push_back(W'(modexp(bs[i+1], es[i+1])));
            end else start = 1'b0;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL b2b_idle_gap_%0d: got busy %b want 0", i, busy);
            end
            @(negedge clk);
            vectors++;
            if (busy !== (i < 2)) begin
                errors++; $display("FAIL b2b_restart_%0d: got busy %b want %b", i, busy, (i < 2));
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (lad_cnt - l0 != 3 || done_cnt - d0 != 3) begin
            errors++; $display("FAIL b2b_counts: got %0d starts %0d dones want 3 3", lad_cnt - l0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exponents();
        test_stub();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mont_exp_sequencer.md
MONT_EXP_SEQUENCER -- requirements
Module: mont_exp_sequencer

Interface
REQ-001 SHALL take widths from defines.vh: `BITS (operand width) and `LOG_BITS (log2 of `BITS); it has no other parameters.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  host request; sampled only in IDLE.
REQ-005 base, exponent, N, N_prime, R2  input  `BITS each  plaintext base, exponent, odd modulus, -N^-1 mod R, R^2 mod N (R = 2^`BITS).
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-008 result  output  `BITS  base^exponent mod N, held until the next accepted start.
REQ-009 lad_start  output  1  one-cycle start pulse to the Montgomery ladder.
REQ-010 lad_base_mont, lad_one_mont, lad_exponent, lad_N, lad_N_prime  output  `BITS each  registered ladder operands.
REQ-011 lad_finish  input  1  ladder completion pulse.
REQ-012 lad_result  input  `BITS  ladder result in the Montgomery domain; valid while lad_finish=1.

Function
REQ-013 SHALL instantiate one combinational montgomery_mult (P = A*B*R^-1 mod N) on the registered N and N_prime.
REQ-014 SHALL capture base, exponent, N, N_prime and R2 in the cycle start=1 is seen in IDLE; inputs in later cycles SHALL be ignored.
REQ-015 States SHALL be IDLE, TO_BASE, TO_ONE, LAD_GO, LAD_WAIT, FROM_MONT, DONE; encoding is free.
REQ-016 IDLE->TO_BASE on start; otherwise SHALL stay in IDLE.
REQ-017 TO_BASE: SHALL register base_mont = MM(base_reg, R2_reg); next state TO_ONE.
REQ-018 TO_ONE: SHALL register one_mont = MM(1, R2_reg); next state LAD_GO.
REQ-019 LAD_GO: lad_start=1 for exactly this cycle, with all lad_* operands already stable; next state LAD_WAIT.
REQ-020 LAD_WAIT: SHALL stay until lad_finish=1, then capture lad_result; next state FROM_MONT.
REQ-021 A lad_finish arriving in any state other than LAD_WAIT SHALL be ignored.
REQ-022 FROM_MONT: SHALL register result = MM(lad_result_reg, 1); next state DONE.
REQ-023 DONE: done=1; next state IDLE. A start held high is accepted in the following IDLE cycle.
REQ-024 Latency: start accepted at cycle 0 gives lad_start at cycle 3; lad_finish at cycle k gives done at cycle k+2.
REQ-025 lad_start and done SHALL never be high outside LAD_GO and DONE respectively.
REQ-026 Every datapath register SHALL be exactly `BITS wide; constant 1 SHALL be zero-extended to `BITS.
REQ-027 Any unexpected state SHALL return to IDLE on the next cycle.

Reset
REQ-028 While rst=1, all registers SHALL clear to 0 and the state SHALL go to IDLE on the next edge; busy=0, done=0, lad_start=0, result=0.
REQ-029 Reset mid-operation, including during LAD_WAIT, SHALL abort with no done pulse; the ladder shares rst.
REQ-030 start asserted in the same cycle as rst SHALL be ignored.

Verification (bench `BITS=8, N=13, N_prime=59, R2=3, real ladder unless noted)
REQ-031 base=2, exponent=5, start pulse -> lad_base_mont=5, lad_one_mont=9, lad_start at cycle 3, done pulse with result=6.
REQ-032 base=7, exponent=0 -> result=1; base=0, exponent=9 -> result=0.
REQ-033 Stub ladder returns lad_finish 40 cycles after lad_start with lad_result=9 -> result=1, done exactly 2 cycles after lad_finish, busy high throughout.
REQ-034 start pulsed while busy, and a spurious lad_finish during TO_ONE -> both ignored; a single done pulse with the correct result.
REQ-035 rst asserted during LAD_WAIT -> next cycle IDLE, busy=0, result=0, no done; a fresh start then gives a correct result.
REQ-036 start held high continuously for 3 operations -> 3 done pulses separated by exactly one IDLE cycle, with no lad_start overlap.
